// File: rtl/dev_board_pkg.sv
// Shared dev-board definitions: key channel FSM encoding and board timing defaults.
package dev_board_pkg;

   localparam int CLK_FREQ_HZ     = 50_000_000;
   localparam int DEF_DEB_CYCLES  = CLK_FREQ_HZ / 50;  // 20 ms
   localparam int DEF_LONG_CYCLES = CLK_FREQ_HZ;       // 1 s

   typedef enum logic [1:0] {
      KEY_RELEASED   = 2'd0,
      KEY_PRESS_DB   = 2'd1,
      KEY_PRESSED    = 2'd2,
      KEY_RELEASE_DB = 2'd3
   } key_fsm_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM, hold counter for long-press detection.
module key_debounce_ch
   import dev_board_pkg::*;
#(
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
   parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_i,
   output logic state_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int DEB_W  = $clog2(DEB_CYCLES);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

   key_fsm_e          state_q;
   logic [1:0]        sync_q;
   logic [DEB_W-1:0]  deb_q;
   logic [HOLD_W-1:0] hold_q;
   logic              fired_q;
   logic              level_q;
   logic              press_q;
   logic              release_q;
   logic              long_q;
   logic              synced;

   assign synced = sync_q[1];

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         // NOTE: synchroniser resets to the released level so a held key re-debounces as a new press.
         sync_q    <= 2'b00;
         state_q   <= KEY_RELEASED;
         deb_q     <= '0;
         hold_q    <= '0;
         fired_q   <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], key_i};
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         case (state_q)
            KEY_RELEASED: begin
               if (synced) begin
                  state_q <= KEY_PRESS_DB;
                  deb_q   <= '0;
               end
            end
            KEY_PRESS_DB: begin
               if (!synced) begin
                  state_q <= KEY_RELEASED;
                  deb_q   <= '0;
               end else if (deb_q == DEB_LAST) begin
                  state_q <= KEY_PRESSED;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
                  hold_q  <= '0;
                  fired_q <= 1'b0;
               end else begin
                  deb_q <= deb_q + DEB_W'(1);
               end
            end
            default: begin
               // Hold timing runs through release debounce so a brief bounce cannot delay key_long.
               if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_W'(1);
               if (hold_q == HOLD_LAST && !fired_q) begin
                  long_q  <= 1'b1;
                  fired_q <= 1'b1;
               end
               if (state_q == KEY_PRESSED) begin
                  if (!synced) begin
                     state_q <= KEY_RELEASE_DB;
                     deb_q   <= '0;
                  end
               end else if (synced) begin
                  state_q <= KEY_PRESSED;
                  deb_q   <= '0;
               end else if (deb_q == DEB_LAST) begin
                  state_q   <= KEY_RELEASED;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  deb_q <= deb_q + DEB_W'(1);
               end
            end
         endcase
      end
   end

   assign state_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

// File: rtl/key_scan.sv
// Multi-key debounced reader: normalises pin polarity, then one debounce channel per key.
module key_scan
   import dev_board_pkg::*;
#(
   parameter int KEY_NUM        = 4,
   parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
   parameter int LONG_CYCLES    = DEF_LONG_CYCLES,
   parameter int KEY_ACTIVE_LOW = 1
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [KEY_NUM-1:0] key_in,
   output logic [KEY_NUM-1:0] key_state,
   output logic [KEY_NUM-1:0] key_press,
   output logic [KEY_NUM-1:0] key_release,
   output logic [KEY_NUM-1:0] key_long
);

   logic [KEY_NUM-1:0] key_norm;

   assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_in : key_in;

   for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
      key_debounce_ch #(
         .DEB_CYCLES  (DEB_CYCLES),
         .LONG_CYCLES (LONG_CYCLES)
      ) u_ch (
         .sys_clk   (sys_clk),
         .sys_rst   (sys_rst),
         .key_i     (key_norm[i]),
         .state_o   (key_state[i]),
         .press_o   (key_press[i]),
         .release_o (key_release[i]),
         .long_o    (key_long[i])
      );
   end

endmodule

// File: tb/tb_key_scan.sv
// Randomised scoreboard bench for key_scan with a run-length reference model of the debouncer.
module tb_key_scan;

   localparam int KN   = 4;
   localparam int DEB  = 8;
   localparam int LONG = 32;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic [KN-1:0] key_in  = '1;
   logic [KN-1:0] key_state, key_press, key_release, key_long;

   key_scan #(
      .KEY_NUM        (KN),
      .DEB_CYCLES     (DEB),
      .LONG_CYCLES    (LONG),
      .KEY_ACTIVE_LOW (1)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_in),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   always #10 sys_clk = ~sys_clk;

   typedef struct {
      int            cyc;
      logic [KN-1:0] press;
      logic [KN-1:0] rel;
      logic [KN-1:0] lng;
      logic [KN-1:0] state;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   function automatic logic [31:0] pack_rec(input exp_t r);
      return {16'h0, r.state, r.lng, r.rel, r.press};
   endfunction

   // Reference model: a key's accepted level flips once the level seen two edges
   // after the pin has disagreed with it for DEB+1 consecutive edges; long fires
   // exactly LONG edges after the press while the key is still accepted as held.
   initial begin : model
      bit   d1[KN], d2[KN], acc[KN];
      int   run[KN], press_at[KN];
      bit   s;
      exp_t r;
      for (int k = 0; k < KN; k++) begin
         d1[k] = 0; d2[k] = 0; acc[k] = 0; run[k] = 0; press_at[k] = -1000000;
      end
      forever begin
         @(posedge sys_clk);
         cyc++;
         if (sys_rst) begin
            for (int k = 0; k < KN; k++) begin
               d1[k] = 0; d2[k] = 0; acc[k] = 0; run[k] = 0; press_at[k] = -1000000;
            end
         end else begin
            r.cyc = cyc; r.press = '0; r.rel = '0; r.lng = '0; r.state = '0;
            for (int k = 0; k < KN; k++) begin
               s     = d2[k];
               d2[k] = d1[k];
               d1[k] = ~key_in[k];
               if (acc[k] && cyc == press_at[k] + LONG) r.lng[k] = 1'b1;
               if (s != acc[k]) run[k]++;
               else run[k] = 0;
               if (run[k] == DEB + 1) begin
                  acc[k] = ~acc[k];
                  run[k] = 0;
                  if (acc[k]) begin
                     r.press[k]  = 1'b1;
                     press_at[k] = cyc;
                  end else begin
                     r.rel[k] = 1'b1;
                  end
               end
               r.state[k] = acc[k];
            end
            if ((r.press | r.rel | r.lng) != '0) sb.push_back(r);
         end
      end
   end

   initial begin : monitor
      exp_t r;
      logic [KN-1:0] pulses;
      forever begin
         @(negedge sys_clk);
         pulses = key_press | key_release | key_long;
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            r = sb.pop_front();
            check("event", {16'h0, key_state, key_long, key_release, key_press}, pack_rec(r));
         end else if (pulses != '0) begin
            check("spurious_pulse", {16'h0, key_state, key_long, key_release, key_press}, 32'h0);
         end
      end
   end

   initial begin : watchdog
      #(20 * 100_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge sys_clk);
      #2;
   endtask

   // Waits for a pulse of the given kind (0 press, 1 release, 2 long) on key k.
   task automatic wait_event(input int k, input int kind, input int budget,
                             output int at, output logic [KN-1:0] vec);
      at  = -1;
      vec = '0;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         vec = (kind == 0) ? key_press : (kind == 1) ? key_release : key_long;
         if (vec[k]) begin
            at = cyc;
            break;
         end
      end
      #2;
   endtask

   initial begin : stim
      int            c0, p, l, at, bad;
      logic [KN-1:0] vec;
      logic [KN-1:0] lvl;
      int            left[KN];

      // Reset and idle
      cycles(3);
      @(negedge sys_clk);
      check("reset_outputs", {16'h0, key_state, key_long, key_release, key_press}, 32'h0);
      #2 sys_rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if ({key_state, key_long, key_release, key_press} != '0) bad++;
      end
      #2;
      check("idle_quiet", bad, 0);

      // Clean press and release on key 0
      key_in[0] = 1'b0; c0 = cyc;
      wait_event(0, 0, 30, at, vec);
      check("clean_press_edge", at, c0 + 11);
      check("clean_state_hi", key_state, 4'b0001);
      cycles(20);
      key_in[0] = 1'b1; c0 = cyc;
      wait_event(0, 1, 30, at, vec);
      check("clean_release_edge", at, c0 + 11);
      check("clean_state_lo", key_state, 4'b0000);
      cycles(10);

      // Bounce rejection on key 1
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         if (i % 3 == 0) key_in[1] = ~key_in[1];
         @(negedge sys_clk);
         if (key_state[1] || key_press[1] || key_release[1]) bad++;
         #2;
      end
      key_in[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (key_state[1] || key_press[1] || key_release[1]) bad++;
      end
      #2;
      check("bounce_quiet", bad, 0);

      // Long press on key 2 with a short release bounce after key_long
      key_in[2] = 1'b0; c0 = cyc;
      wait_event(2, 0, 30, p, vec);
      check("long_press_edge", p, c0 + 11);
      wait_event(2, 2, 60, l, vec);
      check("long_edge", l, p + LONG);
      key_in[2] = 1'b1;
      cycles(4);
      key_in[2] = 1'b0;
      bad = 0;
      while (cyc < c0 + 80) begin
         @(negedge sys_clk);
         if (key_long[2] || key_release[2]) bad++;
         #2;
      end
      check("long_no_repeat", bad, 0);
      key_in[2] = 1'b1; c0 = cyc;
      wait_event(2, 1, 30, at, vec);
      check("long_release_edge", at, c0 + 11);
      cycles(10);

      // Simultaneous keys
      key_in = '0; c0 = cyc;
      wait_event(0, 0, 30, at, vec);
      check("simul_press_edge", at, c0 + 11);
      check("simul_press_vec", vec, 4'hF);
      cycles(5);
      key_in = '1; c0 = cyc;
      wait_event(3, 1, 30, at, vec);
      check("simul_release_edge", at, c0 + 11);
      check("simul_release_vec", vec, 4'hF);
      cycles(10);

      // Reset mid-press
      key_in[0] = 1'b0; c0 = cyc;
      wait_event(0, 0, 30, at, vec);
      check("pre_reset_press", at, c0 + 11);
      cycles(1);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      check("mid_reset_outputs", {16'h0, key_state, key_long, key_release, key_press}, 32'h0);
      #2 sys_rst = 1'b0; c0 = cyc;
      wait_event(0, 0, 30, at, vec);
      check("post_reset_press", at, c0 + 11);
      cycles(5);
      key_in[0] = 1'b1;
      cycles(20);

      // Randomised segments per key with occasional resets
      lvl = '1;
      for (int k = 0; k < KN; k++) left[k] = 0;
      for (int i = 0; i < 4000; i++) begin
         for (int k = 0; k < KN; k++) begin
            if (left[k] == 0) begin
               lvl[k]  = 1'($urandom_range(0, 1));
               left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(5, 120);
            end
            left[k]--;
         end
         key_in = lvl;
         if ($urandom_range(0, 1499) == 0) begin
            sys_rst = 1'b1;
            cycles(2);
            sys_rst = 1'b0;
         end
         cycles(1);
      end

      key_in = '1;
      cycles(40);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/key_scan.md
# key_scan

Debounced multi-key input reader for the dev board: the input-side counterpart to the LED output drivers. It synchronises the raw push-button pins and debounces each key with its own counter FSM. Per key it reports a clean level plus single-cycle press, release and long-press events, for consumption by display and mode-control logic such as flow_led.

## Interface
- KEY_NUM, 4, number of independent keys
- DEB_CYCLES, 1_000_000, stable-level cycles required to accept a change (20 ms at 50 MHz); must be ≥ 2
- LONG_CYCLES, 50_000_000, held cycles after accepted press before long-press event (1 s at 50 MHz); must be > DEB_CYCLES
- KEY_ACTIVE_LOW, 1, 1: pin low = pressed; 0: pin high = pressed
- sys_clk  in  1  system clock, single clock domain
- sys_rst  in  1  asynchronous, active-high reset
- key_in  in  KEY_NUM  raw, asynchronous key pins
- key_state  out  KEY_NUM  debounced level, 1 = pressed
- key_press  out  KEY_NUM  one-cycle pulse on accepted press
- key_release  out  KEY_NUM  one-cycle pulse on accepted release
- key_long  out  KEY_NUM  one-cycle pulse, at most once per press

## Operation
- Each key has an independent channel; no cross-key interaction.
- Input path per bit:
  - Polarity normalisation (pressed = 1).
  - Then 2-FF synchroniser.
- FSM states per channel: RELEASED, PRESS_DB, PRESSED, RELEASE_DB.
  - RELEASED: synced pressed → PRESS_DB, debounce counter cleared.
  - PRESS_DB:
    - Synced released → RELEASED, counter cleared; no event.
    - Else counter increments.
    - Counter == DEB_CYCLES-1 while pressed → PRESSED; key_state←1, key_press pulse, hold counter cleared, long-fired flag cleared.
  - PRESSED:
    - Hold counter increments, saturating at LONG_CYCLES.
    - When it reaches LONG_CYCLES-1 and long-fired is clear → key_long pulse, set long-fired.
    - Synced released → RELEASE_DB, debounce counter cleared.
  - RELEASE_DB:
    - Hold counter keeps counting, and key_long may still fire here.
    - Synced pressed → PRESSED, debounce counter cleared; no event, hold counter not reset.
    - Counter == DEB_CYCLES-1 while released → RELEASED; key_state←0, key_release pulse.
- key_long never fires after key_release of the same press. A new press restarts the hold counter.
- Counter widths: $clog2(DEB_CYCLES) and $clog2(LONG_CYCLES+1); no wrap, since counters are cleared or saturated.

## Timing
- Reset (async assert, sync-safe release):
  - State RELEASED; synchroniser FFs hold the released level.
  - All counters and flags 0.
  - key_state, key_press, key_release, key_long = 0.
- Edge 1 is the first sys_clk edge sampling a new stable raw level:
  - Sync output valid after edge 2.
  - FSM leaves RELEASED/PRESSED at edge 3.
  - key_press / key_release plus the key_state change are registered at edge DEB_CYCLES+3.
- key_long is registered at edge LONG_CYCLES after the key_press edge.
- All outputs are registered; pulses are high exactly one cycle.
- A bounce shorter than DEB_CYCLES synced cycles produces no output change.
- Simultaneous events on different keys are independent and may pulse in the same cycle.
- Reset mid-operation:
  - Outputs drop immediately.
  - A key still held at reset release is treated as a new press: key_press fires at edge DEB_CYCLES+3 after release.

## Structure
- Shared package dev_board_pkg holds:
  - FSM state encoding (2-bit: RELEASED=0, PRESS_DB=1, PRESSED=2, RELEASE_DB=3).
  - Board default constants: CLK_FREQ_HZ=50_000_000, default DEB_CYCLES and LONG_CYCLES.
- Sub-module key_debounce_ch contains synchroniser, FSM and counters for one key. key_scan instantiates it KEY_NUM times via generate and handles polarity.

## Test plan
All scenarios use KEY_NUM=4, DEB_CYCLES=8, LONG_CYCLES=32, KEY_ACTIVE_LOW=1, sys_clk period 20 ns.
- Reset and idle: all pins high, sys_rst pulse → all outputs 0 for 100 cycles.
- Clean press: key_in[0] low from edge 1 → key_press[0] one cycle at edge 11, key_state[0]=1 thereafter. Clean release → key_release[0] at edge 11 after release, key_state[0]=0.
- Bounce rejection: key_in[1] toggles low/high every 3 cycles for 60 cycles, then stays high → no pulses, key_state[1]=0 throughout.
- Long press: key_in[2] held low 80 cycles → key_press at edge 11, one key_long exactly 32 edges later, no further key_long. Release bounce of 4 cycles in PRESSED → no key_release.
- Simultaneous keys: key_in[3:0] all go low on the same edge → all four key_press bits pulse together at edge 11.
- Reset mid-press: key_in[0] held low, sys_rst asserted 1 cycle after key_press then released → outputs 0 during reset, key_press[0] again at edge 11 after release.
